// File: rtl/if_pkg.sv
// if_pkg: shared types and constants for the instruction-fetch stage.
//   if_state_t : fetch FSM state encoding
//   NOP_INSTR  : value presented on instr_out while nothing has been fetched
//   PC_STEP    : byte distance between sequential instructions
package if_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2,
        DROP = 2'd3
    } if_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam int unsigned PC_STEP   = 4;

endpackage

// File: rtl/if_perf_counters.sv
// if_perf_counters: free-running, wrapping performance counters for if_fetch.
// Ports:
//   clk, reset       - clock, asynchronous active-low reset
//   valid_in         - fetch stage output valid
//   stall_in         - downstream stall
//   fetch_count_out  - number of instructions consumed downstream
//   stall_count_out  - number of cycles a valid instruction was stalled
module if_perf_counters (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_in,
    input  logic        stall_in,
    output logic [31:0] fetch_count_out,
    output logic [31:0] stall_count_out
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_count_out <= '0;
            stall_count_out <= '0;
        end else begin
            if (valid_in && !stall_in)
                fetch_count_out <= fetch_count_out + 32'd1;
            if (valid_in && stall_in)
                stall_count_out <= stall_count_out + 32'd1;
        end
    end

endmodule

// File: rtl/if_fetch.sv
// if_fetch: instruction-fetch stage feeding the IF/ID register.
// Owns the PC, runs a req/ack handshake with instruction memory, absorbs
// downstream stalls with a one-entry hold buffer and services redirects,
// discarding a response that is already in flight.
// Ports:
//   clk, reset                    - clock, asynchronous active-low reset
//   stall_in                      - downstream cannot accept
//   redirect_in, redirect_pc_in   - taken branch/jump and its target
//   imem_req_out, imem_addr_out   - fetch request and address
//   imem_ack_in, imem_rdata_in    - one-cycle response strobe and instruction
//   valid_out, instr_out, pc_out  - instruction presented downstream
//   fetch_count_out, stall_count_out - only when IF_PERF_EN is defined
// Build option: `define IF_PERF_EN adds the performance counter outputs.
module if_fetch
    import if_pkg::*;
#(
    parameter int unsigned      XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall_in,
    input  logic            redirect_in,
    input  logic [XLEN-1:0] redirect_pc_in,
    output logic            imem_req_out,
    output logic [XLEN-1:0] imem_addr_out,
    input  logic            imem_ack_in,
    input  logic [XLEN-1:0] imem_rdata_in,
    output logic            valid_out,
    output logic [XLEN-1:0] instr_out,
    output logic [XLEN-1:0] pc_out
`ifdef IF_PERF_EN
    ,
    output logic [31:0]     fetch_count_out,
    output logic [31:0]     stall_count_out
`endif
);

    if_state_t       state_q, state_n;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_n;
    logic [XLEN-1:0] hold_instr_q, hold_pc_q;

    logic slot_free;
    logic load_out;   // acked instruction goes straight to the output
    logic park;       // acked instruction goes to the hold buffer
    logic unpark;     // hold buffer moves to the output
    logic consume;

    assign slot_free = !valid_out || !stall_in;
    assign consume   = valid_out && !stall_in;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state_q <= IDLE;
        else
            state_q <= state_n;
    end

    // Next-state logic
    always_comb begin
        state_n = state_q;
        case (state_q)
            IDLE: state_n = REQ;
            REQ: begin
                if (redirect_in)
                    state_n = imem_ack_in ? REQ : DROP;
                else if (imem_ack_in && !slot_free)
                    state_n = HOLD;
            end
            HOLD: begin
                if (redirect_in || !stall_in)
                    state_n = REQ;
            end
            DROP: begin
                if (imem_ack_in)
                    state_n = REQ;
            end
            default: state_n = IDLE;
        endcase
    end

    // Output / datapath control decode
    always_comb begin
        imem_req_out = (state_q == REQ) || (state_q == DROP);
        load_out     = !redirect_in && (state_q == REQ) && imem_ack_in && slot_free;
        park         = !redirect_in && (state_q == REQ) && imem_ack_in && !slot_free;
        unpark       = !redirect_in && (state_q == HOLD) && !stall_in;
        fetch_pc_n   = fetch_pc_q;
        if (redirect_in)
            fetch_pc_n = redirect_pc_in & ~XLEN'(3);
        else if ((state_q == REQ) && imem_ack_in)
            fetch_pc_n = fetch_pc_q + XLEN'(PC_STEP);
    end

    // fetch_pc_q is the next address to fetch; imem_addr_out tracks it except
    // while a discarded response is still outstanding (DROP), where the bus
    // address must stay on the old request until its ack.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_q    <= RESET_PC;
            imem_addr_out <= RESET_PC;
        end else begin
            fetch_pc_q <= fetch_pc_n;
            if (state_n != DROP)
                imem_addr_out <= fetch_pc_n;
        end
    end

    // Output registers and hold buffer. Hold buffer occupancy is state==HOLD.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_out    <= 1'b0;
            instr_out    <= XLEN'(NOP_INSTR);
            pc_out       <= '0;
            hold_instr_q <= XLEN'(NOP_INSTR);
            hold_pc_q    <= '0;
        end else begin
            if (redirect_in) begin
                valid_out    <= 1'b0;
                hold_instr_q <= XLEN'(NOP_INSTR);
                hold_pc_q    <= '0;
            end else if (load_out) begin
                valid_out <= 1'b1;
                instr_out <= imem_rdata_in;
                pc_out    <= imem_addr_out;
            end else if (unpark) begin
                valid_out <= 1'b1;
                instr_out <= hold_instr_q;
                pc_out    <= hold_pc_q;
            end else if (consume) begin
                valid_out <= 1'b0;
            end
            if (park) begin
                hold_instr_q <= imem_rdata_in;
                hold_pc_q    <= imem_addr_out;
            end
        end
    end

`ifdef IF_PERF_EN
    if_perf_counters u_perf (
        .clk             (clk),
        .reset           (reset),
        .valid_in        (valid_out),
        .stall_in        (stall_in),
        .fetch_count_out (fetch_count_out),
        .stall_count_out (stall_count_out)
    );
`endif

endmodule

// File: tb/tb_if_fetch.sv
module tb_if_fetch;
    import if_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall_in;
    logic        redirect_in;
    logic [31:0] redirect_pc_in;
    logic        imem_req_out;
    logic [31:0] imem_addr_out;
    logic        imem_ack_in;
    logic [31:0] imem_rdata_in;
    logic        valid_out;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
`ifdef IF_PERF_EN
    logic [31:0] fetch_count_out;
    logic [31:0] stall_count_out;
`endif

    int vectors    = 0;
    int miscompares = 0;

    if_fetch #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .reset          (reset),
        .stall_in       (stall_in),
        .redirect_in    (redirect_in),
        .redirect_pc_in (redirect_pc_in),
        .imem_req_out   (imem_req_out),
        .imem_addr_out  (imem_addr_out),
        .imem_ack_in    (imem_ack_in),
        .imem_rdata_in  (imem_rdata_in),
        .valid_out      (valid_out),
        .instr_out      (instr_out),
        .pc_out         (pc_out)
`ifdef IF_PERF_EN
        ,
        .fetch_count_out(fetch_count_out),
        .stall_count_out(stall_count_out)
`endif
    );

    always #5 clk = ~clk;

    // Memory image: instruction word at address a is 0xAB00_0000 | a.
    function automatic logic [31:0] mem(input logic [31:0] a);
        return 32'hAB00_0000 | a;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive inputs for the coming rising edge, then advance to the next falling edge.
    task automatic step(input logic ack, input logic stall, input logic redir,
                        input logic [31:0] rpc);
        imem_ack_in    = ack;
        imem_rdata_in  = ack ? mem(imem_addr_out) : 32'h0;
        stall_in       = stall;
        redirect_in    = redir;
        redirect_pc_in = rpc;
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b0; stall_in = 1'b0; redirect_in = 1'b0; redirect_pc_in = '0;
        imem_ack_in = 1'b0; imem_rdata_in = '0;
        repeat (2) @(negedge clk);

        // Reset values
        chk("rst_req",   32'(imem_req_out), 32'd0);
        chk("rst_addr",  imem_addr_out, 32'h0);
        chk("rst_valid", 32'(valid_out), 32'd0);
        chk("rst_instr", instr_out, 32'h0000_0013);
        chk("rst_pc",    pc_out, 32'h0);
        chk("rst_state", 32'(dut.state_q), 32'(IDLE));

        // Release: one IDLE cycle, request in the second cycle
        reset = 1'b1;
        chk("idle_req", 32'(imem_req_out), 32'd0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        chk("c1_req",  32'(imem_req_out), 32'd1);
        chk("c1_addr", imem_addr_out, 32'h0);

        // Zero-wait memory streams one instruction per cycle
        step(1'b1, 1'b0, 1'b0, 32'h0);
        chk("c2_valid", 32'(valid_out), 32'd1);
        chk("c2_pc",    pc_out, 32'h0);
        chk("c2_instr", instr_out, 32'hAB00_0000);
        chk("c2_addr",  imem_addr_out, 32'h4);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        chk("c3_pc",    pc_out, 32'h4);
        chk("c3_instr", instr_out, 32'hAB00_0004);

        // Stall 3 cycles; ack of 0x8 arrives while output is full
        step(1'b1, 1'b1, 1'b0, 32'h0);
        chk("c4_state", 32'(dut.state_q), 32'(HOLD));
        chk("c4_req",   32'(imem_req_out), 32'd0);
        chk("c4_pc",    pc_out, 32'h4);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        chk("c5_pc",    pc_out, 32'h4);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        chk("c6_state", 32'(dut.state_q), 32'(HOLD));
        chk("c6_valid", 32'(valid_out), 32'd1);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        chk("c7_pc",    pc_out, 32'h8);
        chk("c7_instr", instr_out, 32'hAB00_0008);
        chk("c7_state", 32'(dut.state_q), 32'(REQ));
        chk("c7_addr",  imem_addr_out, 32'hC);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        chk("c8_pc",    pc_out, 32'hC);
        chk("c8_instr", instr_out, 32'hAB00_000C);
        chk("c8_addr",  imem_addr_out, 32'h10);

        // Redirect to 0x100 while the request to 0x10 is outstanding
        step(1'b0, 1'b0, 1'b0, 32'h0);
        chk("c9_valid", 32'(valid_out), 32'd0);
        step(1'b0, 1'b0, 1'b1, 32'h100);
        chk("c10_state", 32'(dut.state_q), 32'(DROP));
        chk("c10_req",   32'(imem_req_out), 32'd1);
        chk("c10_addr",  imem_addr_out, 32'h10);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        chk("c11_addr",  imem_addr_out, 32'h10);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        chk("c12_state", 32'(dut.state_q), 32'(REQ));
        chk("c12_addr",  imem_addr_out, 32'h100);
        chk("c12_valid", 32'(valid_out), 32'd0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        chk("c13_valid", 32'(valid_out), 32'd1);
        chk("c13_pc",    pc_out, 32'h100);
        chk("c13_instr", instr_out, 32'hAB00_0100);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        chk("c14_addr",  imem_addr_out, 32'h104);

        // Redirect and ack together, misaligned target 0x102
        step(1'b1, 1'b0, 1'b1, 32'h102);
        chk("c15_valid", 32'(valid_out), 32'd0);
        chk("c15_addr",  imem_addr_out, 32'h100);
        chk("c15_state", 32'(dut.state_q), 32'(REQ));
        step(1'b1, 1'b0, 1'b0, 32'h0);
        chk("c16_pc",    pc_out, 32'h100);
        chk("c16_instr", instr_out, 32'hAB00_0100);
        chk("c16_req",   32'(imem_req_out), 32'd1);

        // Asynchronous reset mid-request
        imem_ack_in = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("areset_req",   32'(imem_req_out), 32'd0);
        chk("areset_valid", 32'(valid_out), 32'd0);
        chk("areset_state", 32'(dut.state_q), 32'(IDLE));
        chk("areset_addr",  imem_addr_out, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        imem_ack_in   = 1'b1;   // stray ack during the IDLE cycle
        imem_rdata_in = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("d1_valid", 32'(valid_out), 32'd0);
        chk("d1_state", 32'(dut.state_q), 32'(REQ));
        chk("d1_addr",  imem_addr_out, 32'h0);

        // Restart stream: 10 consumes, then 4 stalled-valid cycles
        step(1'b1, 1'b0, 1'b0, 32'h0);
        for (int k = 2; k <= 11; k++) begin
            chk($sformatf("d%0d_pc", k), pc_out, 32'(4 * (k - 2)));
            step(1'b1, 1'b0, 1'b0, 32'h0);
        end
        chk("d12_pc", pc_out, 32'h28);
        for (int k = 0; k < 4; k++)
            step(1'b0, 1'b1, 1'b0, 32'h0);
        chk("d16_valid", 32'(valid_out), 32'd1);
        chk("d16_pc",    pc_out, 32'h28);
`ifdef IF_PERF_EN
        chk("perf_fetch", fetch_count_out, 32'd10);
        chk("perf_stall", stall_count_out, 32'd4);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
